// File: rtl/run_ctrl_pkg.sv
// Shared types and default timing values for the CPU run controller.
package run_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, STEP, RUN, HALTED} run_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES   = 12000;
  localparam int unsigned DEF_LONG_PRESS_CYCLES = 6000000;
  localparam int unsigned DEF_CLK_DIV           = 4;
  localparam int unsigned DEF_COUNT_W           = 16;

endpackage

// File: rtl/button_press_decoder.sv
// Pushbutton front end: 2-flop synchronizer, debounce, short/long press pulses.
module button_press_decoder
  import run_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic short_press,
  output logic long_press
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HW = $clog2(LONG_PRESS_CYCLES);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          deb;
  logic          deb_q;
  logic          long_done;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;

  // Two-stage synchronizer for the asynchronous button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= start;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb     <= 1'b0;
      deb_cnt <= '0;
    end else if (sync2 != deb) begin
      if (deb_cnt == DEB_LAST) begin
        deb     <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  // Hold timer: zero while released, counts (saturating) while held; long_done
  // stays set until release so the falling edge can tell long from short.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_q     <= 1'b0;
      hold_cnt  <= '0;
      long_done <= 1'b0;
    end else begin
      deb_q <= deb;
      if (!deb) begin
        hold_cnt  <= '0;
        long_done <= 1'b0;
      end else begin
        if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 1'b1;
        if (long_press) long_done <= 1'b1;
      end
    end
  end

  assign long_press  = deb && (hold_cnt == HOLD_LAST) && !long_done;
  assign short_press = deb_q && !deb && !long_done;

endmodule

// File: rtl/cpu_run_controller.sv
// Single-button run controller: step / free-run / halt sequencing of the CPU
// via a one-clock enable, plus status LEDs and an enable-pulse counter.
module cpu_run_controller
  import run_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int unsigned CLK_DIV           = DEF_CLK_DIV,
  parameter int unsigned COUNT_W           = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               cpu_halt,
  output logic               cpu_en,
  output logic               running,
  output logic               halted,
  output logic [COUNT_W-1:0] cycle_count
);

  localparam int unsigned    DVW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DVW-1:0] DIV_LAST = DVW'(CLK_DIV - 1);

  run_state_t     state;
  run_state_t     state_n;
  logic [DVW-1:0] div;
  logic [DVW-1:0] div_n;
  logic           en_n;
  logic           running_n;
  logic           halted_n;
  logic           short_press;
  logic           long_press;

  button_press_decoder #(
    .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
    .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
  ) u_button (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .short_press (short_press),
    .long_press  (long_press)
  );

  // State, divider and all outputs are registered; counter tallies issued enables.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      div         <= '0;
      cpu_en      <= 1'b0;
      running     <= 1'b0;
      halted      <= 1'b0;
      cycle_count <= '0;
    end else begin
      state   <= state_n;
      div     <= div_n;
      cpu_en  <= en_n;
      running <= running_n;
      halted  <= halted_n;
      if (cpu_en) cycle_count <= cycle_count + 1'b1;
    end
  end

  // Next-state logic; cpu_en is decided one cycle ahead, so halt/long press in
  // the deciding cycle suppress the pulse that would otherwise follow.
  always_comb begin
    state_n = state;
    div_n   = '0;
    en_n    = 1'b0;
    case (state)
      IDLE: begin
        if (short_press) begin
          state_n = STEP;
          en_n    = 1'b1;
        end else if (long_press) begin
          state_n = RUN;
        end
      end
      STEP: state_n = IDLE;
      RUN: begin
        if (cpu_halt) begin
          state_n = HALTED;
        end else if (long_press) begin
          state_n = IDLE;
        end else begin
          div_n = (div == DIV_LAST) ? '0 : div + 1'b1;
          en_n  = (div == DIV_LAST);
        end
      end
      HALTED: begin
        if (long_press) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    running_n = (state_n == RUN);
    halted_n  = (state_n == HALTED);
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller with an event-timed reference model.
module tb_cpu_run_controller;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int DIV  = 3;
  localparam int CW   = 4;
  localparam int NEV  = 2048;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          cpu_halt = 1'b0;
  logic          cpu_en;
  logic          running;
  logic          halted;
  logic [CW-1:0] cycle_count;

  always #5 clk = ~clk;

  cpu_run_controller #(
    .DEBOUNCE_CYCLES   (DEB),
    .LONG_PRESS_CYCLES (LONG),
    .CLK_DIV           (DIV),
    .COUNT_W           (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cpu_halt    (cpu_halt),
    .cpu_en      (cpu_en),
    .running     (running),
    .halted      (halted),
    .cycle_count (cycle_count)
  );

  int vectors = 0;
  int miscompares = 0;
  int n = 0;

  // press events, indexed by the edge that precedes their decision cycle
  bit short_at[NEV];
  bit long_at[NEV];

  // reference model
  bit m_run, m_halt, m_step, m_en;
  int m_entry, m_cnt;

  // observations of the DUT (stimulus timing and pinned checks only)
  int dut_pulses, last_en_edge, run_edge, first_en_after_run;
  bit prev_running;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, n);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_halt = 0; m_step = 0; m_en = 0;
    m_entry = 0; m_cnt = 0;
  endtask

  // Outputs after edge n+1 from the inputs seen in cycle (n, n+1).
  task automatic model_advance();
    bit sp, lp, nen;
    sp  = (n < NEV) ? short_at[n] : 1'b0;
    lp  = (n < NEV) ? long_at[n]  : 1'b0;
    nen = 0;
    m_cnt = (m_cnt + int'(m_en)) % (1 << CW);
    if (m_run) begin
      if (cpu_halt) begin m_run = 0; m_halt = 1; end
      else if (lp) m_run = 0;
      else if (((n + 1 - m_entry) % DIV) == 0) nen = 1;
    end else if (m_halt) begin
      if (lp) m_halt = 0;
    end else if (m_step) begin
      m_step = 0;
    end else if (sp) begin
      m_step = 1; nen = 1;
    end else if (lp) begin
      m_run = 1; m_entry = n + 1;
    end
    m_en = nen;
  endtask

  // Compare at the falling edge, advance the model, step to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (reset) model_reset();
    check("cpu_en", int'(cpu_en), int'(m_en));
    check("running", int'(running), int'(m_run));
    check("halted", int'(halted), int'(m_halt));
    check("cycle_count", int'(cycle_count), m_cnt);
    if (running && !prev_running) begin
      run_edge = n;
      first_en_after_run = -1;
    end
    prev_running = running;
    if (cpu_en) begin
      dut_pulses++;
      last_en_edge = n;
      if (first_en_after_run < 0) first_en_after_run = n;
    end
    if (!reset) model_advance();
    @(posedge clk);
    n++;
    #1;
  endtask

  task automatic idle(input int c);
    repeat (c) tick();
  endtask

  // Clean press of len clocks; schedules the press event it must produce.
  task automatic press(input int len);
    int k;
    k = n;
    if (len >= LONG) long_at[k + 1 + DEB + LONG] = 1'b1;
    else if (len >= DEB) short_at[k + len + 2 + DEB] = 1'b1;
    start = 1'b1;
    repeat (len) tick();
    start = 1'b0;
  endtask

  task automatic wait_pulses(input int target, input int budget);
    int b;
    b = 0;
    while (dut_pulses < target && b < budget) begin
      tick();
      b++;
    end
    if (dut_pulses < target) check("pulse_wait_timeout", dut_pulses, target);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    check("rst_cpu_en", int'(cpu_en), 0);
    check("rst_running", int'(running), 0);
    check("rst_halted", int'(halted), 0);
    check("rst_count", int'(cycle_count), 0);
    reset = 1'b0;
    dut_pulses = 0;
  endtask

  initial begin
    int k, rel, p0;
    model_reset();
    prev_running = 0; run_edge = -1; first_en_after_run = -1; last_en_edge = -1;
    dut_pulses = 0;
    @(posedge clk);
    n = 1;
    #1;
    do_reset();
    idle(5);

    // reset mid-run, then a short press single-steps
    press(30);
    wait_pulses(4, 40);
    check("run_before_reset", int'(running), 1);
    do_reset();
    idle(10);
    p0 = dut_pulses;
    press(10);
    rel = n;
    idle(15);
    check("step_latency", last_en_edge - rel, 7);
    check("step_pulses", dut_pulses - p0, 1);
    check("step_count", int'(cycle_count), 1);
    check("step_running", int'(running), 0);

    // glitch shorter than the debounce window
    p0 = dut_pulses;
    press(3);
    idle(15);
    check("glitch_pulses", dut_pulses - p0, 0);
    check("glitch_count", int'(cycle_count), 1);

    // long press into RUN, ten pulses
    do_reset();
    idle(5);
    k = n;
    press(30);
    check("run_entry_edge", run_edge - k, 26);
    wait_pulses(10, 60);
    check("count_after_10", int'(cycle_count), 10);
    check("running_after_10", int'(running), 1);

    // halt raised in the cycle the next pulse is due
    wait_pulses(11, 10);
    tick();
    cpu_halt = 1'b1;
    p0 = dut_pulses;
    tick();
    tick();
    check("halt_halted", int'(halted), 1);
    check("halt_running", int'(running), 0);
    check("halt_count", int'(cycle_count), 11);
    check("halt_no_pulse", dut_pulses - p0, 0);
    press(8);
    idle(15);
    check("halt_short_ignored", int'(halted), 1);
    press(25);
    idle(10);
    check("halt_long_exit", int'(halted), 0);
    check("halt_exit_running", int'(running), 0);
    check("halt_total_pulses", dut_pulses - p0, 0);
    cpu_halt = 1'b0;
    idle(3);

    // counter wrap, pause, re-entry
    do_reset();
    idle(5);
    press(30);
    wait_pulses(17, 80);
    check("wrap_count", int'(cycle_count), 1);
    press(25);
    idle(8);
    check("pause_running", int'(running), 0);
    k = n;
    press(30);
    check("reentry_edge", run_edge - k, 26);
    wait_pulses(dut_pulses + 1, 40);
    check("reentry_first_pulse", first_en_after_run - run_edge, DIV);
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
